wb_regfile_unit: RTL
====================

// Module: wb_regfile_unit
// PURPOSE
//  Write-back end of the MEM/WB pipeline register: consumes the latched load data, ALU result,
//  PC, destination index, WBsel and Regwrite fields. Extracts and extends load data, selects the
//  write-back value and commits it to a 32-entry register file (x0 hardwired to zero).
//  Also provides two bypassed read ports to the decode stage, and a forwarding tap for EX.
// PARAMETERS
//  datawidth  32  register/data width in bits
//  regindex   5   register index width; register count = 2**regindex
// PORTS
//  clk             in   1          rising-edge clock
//  rst             in   1          asynchronous, active-high reset
//  en              in   1          write-back enable; 0 = pipeline stalled, no state change
//  DataMEM_in      in   datawidth  raw aligned load word from MEM/WB
//  DataALU_in      in   datawidth  ALU result (load address for loads) from MEM/WB
//  MEM_WB_PC_in    in   32         PC of the instruction in WB
//  regdindex_in    in   regindex   destination register index
//  WBsel_in        in   2          00 ALU, 01 load data, 10 PC+4, 11 no write-back
//  Regwrite_in     in   1          register write request
//  load_funct3_in  in   3          000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  rs1_index       in   regindex   decode read port 1 index
//  rs2_index       in   regindex   decode read port 2 index
//  rs1_data        out  datawidth  read data port 1 (combinational, bypassed)
//  rs2_data        out  datawidth  read data port 2 (combinational, bypassed)
//  wb_data_out     out  datawidth  selected write-back value (combinational forwarding tap)
//  wb_we_out       out  1          write qualifies this cycle (see write rule)
//  wb_rd_out       out  regindex   = regdindex_in
//  retire_count    out  32         number of register writes performed
//  misalign_err    out  1          sticky flag: misaligned load reached WB
// BEHAVIOUR
//  Reset: while rst=1, asynchronously clear all registers, retire_count and misalign_err to 0.
//   A write in the same cycle as rst is lost. Reset mid-stall behaves identically.
//  Load extract (WBsel=01), offset = DataALU_in[1:0]:
//   - LB/LBU: byte at bits [8*off+7 : 8*off], sign- or zero-extended.
//   - LH/LHU: half at bits [16*off[1]+15 : 16*off[1]], sign- or zero-extended.
//   - LW: full word. Other funct3 codes: full word.
//  Misaligned: LH/LHU with off[0]=1, or LW with off!=0 (only when WBsel=01).
//  wb_data_out:
//   - 00: DataALU_in.
//   - 01: extracted load.
//   - 10: MEM_WB_PC_in+4, modulo 2**32.
//   - 11: 0.
//  Write rule: wb_we_out = en & Regwrite_in & (WBsel!=11) & (rd!=0) & ~misaligned.
//   - On posedge with wb_we_out=1: reg[rd] <= wb_data_out, and retire_count += 1
//     (wraps 0xFFFFFFFF -> 0).
//  Misaligned load with en & Regwrite_in: no write; misalign_err <= 1.
//   - misalign_err stays set until rst.
//  Read ports: index 0 -> 0.
//   - Else if wb_we_out and index==rd -> wb_data_out (write-through, same cycle).
//   - Else stored value.
//   - Both ports may hit the same or the bypassed register simultaneously.
//  en=0: no register, counter or flag update; outputs remain combinational functions of inputs.
//  Latency: a write is visible on read ports in the same cycle via bypass, and from storage the
//   next cycle.
// TESTING
//  1. rst pulse mid-run after writes -> all rsN_data=0, retire_count=0, misalign_err=0 immediately.
//  2. WBsel=00, ALU=0xDEADBEEF, rd=5, Regwrite=1, en=1 -> same cycle rs1(5)=0xDEADBEEF;
//     next cycle stored, retire_count=1.
//  3. WBsel=01, Mem=0x80FF7F01, ALU[1:0]=2, LB -> 0xFFFFFFFF; LBU -> 0x000000FF;
//     LH, off=2 -> 0xFFFF80FF.
//  4. WBsel=10, PC=0x00000100, rd=1 -> x1=0x00000104; rd=0 -> x0 stays 0,
//     wb_we_out=0, count unchanged.
//  5. LW with ALU[1:0]=1, Regwrite=1 -> no write, misalign_err=1 and held through later valid writes.
//  6. en=0 with Regwrite=1 -> register and retire_count unchanged;
//     retire_count preset near 0xFFFFFFFF wraps to 0 after next write.

Source files
------------

// File: rtl/wb_regfile_unit.sv
// Write-back stage: load extraction, write-back select and a 32-entry register file.
// It provides two bypassed decode read ports and a forwarding tap for EX.
module wb_regfile_unit #(
  parameter int unsigned datawidth = 32,
  parameter int unsigned regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [datawidth-1:0] DataMEM_in,
  input  logic [datawidth-1:0] DataALU_in,
  input  logic [31:0]          MEM_WB_PC_in,
  input  logic [regindex-1:0]  regdindex_in,
  input  logic [1:0]           WBsel_in,
  input  logic                 Regwrite_in,
  input  logic [2:0]           load_funct3_in,
  input  logic [regindex-1:0]  rs1_index,
  input  logic [regindex-1:0]  rs2_index,
  output logic [datawidth-1:0] rs1_data,
  output logic [datawidth-1:0] rs2_data,
  output logic [datawidth-1:0] wb_data_out,
  output logic                 wb_we_out,
  output logic [regindex-1:0]  wb_rd_out,
  output logic [31:0]          retire_count,
  output logic                 misalign_err
);

  localparam int unsigned nregs = 2 ** regindex;

  localparam logic [1:0] wbsel_alu  = 2'b00;
  localparam logic [1:0] wbsel_load = 2'b01;
  localparam logic [1:0] wbsel_pc4  = 2'b10;

  localparam logic [2:0] f3_lb  = 3'b000;
  localparam logic [2:0] f3_lh  = 3'b001;
  localparam logic [2:0] f3_lw  = 3'b010;
  localparam logic [2:0] f3_lbu = 3'b100;
  localparam logic [2:0] f3_lhu = 3'b101;

  logic [datawidth-1:0] regs [nregs];

  logic [1:0]           off_c;
  logic [7:0]           byte_c;
  logic [15:0]          half_c;
  logic [datawidth-1:0] load_c;
  logic                 misaligned_c;

  assign off_c     = DataALU_in[1:0];
  assign wb_rd_out = regdindex_in;

  // Byte/half lane selection and extension of the raw load word
  always_comb begin
    byte_c = DataMEM_in[7:0];
    case (off_c)
      2'd1:    byte_c = DataMEM_in[15:8];
      2'd2:    byte_c = DataMEM_in[23:16];
      2'd3:    byte_c = DataMEM_in[31:24];
      default: byte_c = DataMEM_in[7:0];
    endcase
    half_c = off_c[1] ? DataMEM_in[31:16] : DataMEM_in[15:0];
    case (load_funct3_in)
      f3_lb:   load_c = {{(datawidth-8){byte_c[7]}}, byte_c};
      f3_lbu:  load_c = {{(datawidth-8){1'b0}}, byte_c};
      f3_lh:   load_c = {{(datawidth-16){half_c[15]}}, half_c};
      f3_lhu:  load_c = {{(datawidth-16){1'b0}}, half_c};
      default: load_c = DataMEM_in;
    endcase
  end

  always_comb begin
    misaligned_c = 1'b0;
    if (WBsel_in == wbsel_load) begin
      if (load_funct3_in[1:0] == 2'b01)
        misaligned_c = off_c[0];
      else if (load_funct3_in == f3_lw)
        misaligned_c = (off_c != 2'd0);
    end
  end

  always_comb begin
    case (WBsel_in)
      wbsel_alu:  wb_data_out = DataALU_in;
      wbsel_load: wb_data_out = load_c;
      wbsel_pc4:  wb_data_out = datawidth'(MEM_WB_PC_in + 32'd4);
      default:    wb_data_out = '0;
    endcase
  end

  assign wb_we_out = en & Regwrite_in & (WBsel_in != 2'b11)
                   & (regdindex_in != '0) & ~misaligned_c;

  // Read ports: x0 is zero, a same-cycle write is forwarded ahead of storage
  always_comb begin
    rs1_data = regs[rs1_index];
    if (rs1_index == '0)
      rs1_data = '0;
    else if (wb_we_out && (rs1_index == regdindex_in))
      rs1_data = wb_data_out;
  end

  always_comb begin
    rs2_data = regs[rs2_index];
    if (rs2_index == '0)
      rs2_data = '0;
    else if (wb_we_out && (rs2_index == regdindex_in))
      rs2_data = wb_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < nregs; i++)
        regs[i] <= '0;
      retire_count <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (wb_we_out) begin
        regs[regdindex_in] <= wb_data_out;
        retire_count       <= retire_count + 32'd1;
      end
      if (en && Regwrite_in && misaligned_c)
        misalign_err <= 1'b1;
    end
  end

endmodule
